// File: rtl/data_bridge_tc.sv
// Data-memory responder: 4096-word RAM plus a memory-mapped timer/counter.
// Define BRIDGE_TRACE_EN to print a trace line for every accepted store.
module data_bridge_tc #(
    parameter int          DM_WORDS = 4096,
    parameter logic [31:0] TC_BASE  = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    output logic [31:0] m_data_rdata,
    input  logic [31:0] m_inst_addr,
    output logic        interrupt
);

    localparam int          AW       = $clog2(DM_WORDS);
    localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } tc_state_e;

    logic [31:0] dm_q [DM_WORDS];
    logic [31:0] word_addr;
    logic [31:0] tc_off;
    logic [1:0]  tc_sel;
    logic [AW-1:0] dm_idx;
    logic        dm_hit;
    logic        tc_hit;
    logic        dm_we;
    logic        tc_we;
    logic [31:0] dm_merged;

    tc_state_e   state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_q;

    assign word_addr = {m_data_addr[31:2], 2'b00};
    assign tc_off    = word_addr - TC_BASE;
    assign tc_sel    = tc_off[3:2];
    assign dm_idx    = m_data_addr[AW+1:2];
    assign dm_hit    = m_data_addr < DM_BYTES;
    assign tc_hit    = (word_addr >= TC_BASE) && (word_addr <= TC_BASE + 32'd8);
    assign dm_we     = dm_hit && (m_data_byteen != 4'b0000);
    assign tc_we     = tc_hit && (m_data_byteen == 4'b1111);
    assign interrupt = irq_q & ctrl_q[3];

    always_comb begin
        dm_merged = dm_q[dm_idx];
        for (int b = 0; b < 4; b++) begin
            if (m_data_byteen[b]) begin
                dm_merged[8*b +: 8] = m_data_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        m_data_rdata = 32'h0;
        if (dm_hit) begin
            m_data_rdata = dm_q[dm_idx];
        end else if (tc_hit) begin
            case (tc_sel)
                2'd0:    m_data_rdata = {28'h0, ctrl_q};
                2'd1:    m_data_rdata = preset_q;
                2'd2:    m_data_rdata = count_q;
                default: m_data_rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm_q[i] <= 32'h0;
            end
        end else if (dm_we) begin
            dm_q[dm_idx] <= dm_merged;
        end
    end

    // Software CTRL write is applied last so it overrides the FSM's EN/irq update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'h0;
            preset_q <= 32'h0;
            count_q  <= 32'h0;
            irq_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_q[0]) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_q <= preset_q;
                    state_q <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl_q[0]) begin
                        state_q <= S_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        count_q <= 32'h0;
                        irq_q   <= 1'b1;
                        state_q <= S_INT;
                    end
                end
                S_INT: begin
                    if (ctrl_q[2:1] == 2'b01) begin
                        irq_q   <= 1'b0;
                        state_q <= S_LOAD;
                    end else begin
                        ctrl_q[0] <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (tc_we && tc_sel == 2'd0) begin
                ctrl_q <= m_data_wdata[3:0];
                irq_q  <= 1'b0;
            end
            if (tc_we && tc_sel == 2'd1) begin
                preset_q <= m_data_wdata;
            end
        end
    end

`ifdef BRIDGE_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (dm_we) begin
                $display("%d@%h: *%h <= %h", $time, m_inst_addr, word_addr, dm_merged);
            end
            if (tc_we && tc_sel != 2'd2) begin
                $display("%d@%h: *%h <= %h", $time, m_inst_addr, word_addr, m_data_wdata);
            end
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{m_inst_addr, tc_off[31:4], tc_off[1:0]};

endmodule

// File: tb/tb_data_bridge_tc.sv
// Scoreboard bench for data_bridge_tc: directed stores, reads and timer runs.
// Stimulus queues expected read data/interrupt; a negedge monitor compares.
module tb_data_bridge_tc;

    localparam logic [31:0] TC = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;
    logic [31:0] m_inst_addr;
    logic        interrupt;

    logic        chk_v = 1'b0;
    logic [32:0] exp_q [$];
    string       name_q [$];
    int          nvec = 0;
    int          nmiss = 0;

    logic [31:0] ar_cnt [9] = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0,
                                32'd2, 32'd1, 32'd0, 32'd0};
    logic        ar_irq [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b0};

    data_bridge_tc dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_rdata  (m_data_rdata),
        .m_inst_addr   (m_inst_addr),
        .interrupt     (interrupt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_v) begin
            if (exp_q.size() == 0) begin
                nmiss++;
                $display("FAIL scoreboard: check strobe with empty queue");
            end else begin
                logic [32:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                nvec++;
                if (m_data_rdata !== e[31:0] || interrupt !== e[32]) begin
                    nmiss++;
                    $display("FAIL %s: got rdata=%h irq=%b, want rdata=%h irq=%b",
                             nm, m_data_rdata, interrupt, e[31:0], e[32]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        m_data_addr   = a;
        m_data_wdata  = d;
        m_data_byteen = be;
        @(posedge clk);
        #1;
        m_data_byteen = 4'b0000;
    endtask

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] rd, input logic irq);
        m_data_addr   = a;
        m_data_byteen = 4'b0000;
        exp_q.push_back({irq, rd});
        name_q.push_back(nm);
        chk_v = 1'b1;
        @(posedge clk);
        #1;
        chk_v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        m_data_addr   = 32'h0;
        m_data_wdata  = 32'h0;
        m_data_byteen = 4'b0000;
        m_inst_addr   = 32'h0000_3000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_ctrl",   TC,         32'h0, 1'b0);
        chk("rst_preset", TC + 32'd4, 32'h0, 1'b0);
        chk("rst_count",  TC + 32'd8, 32'h0, 1'b0);
        chk("dm_3ffc_init", 32'h3FFC, 32'h0, 1'b0);

        wr(32'h10, 32'h1122_3344, 4'b1111);
        chk("dm_full", 32'h10, 32'h1122_3344, 1'b0);
        wr(32'h10, 32'hAABB_CCDD, 4'b0100);
        chk("dm_lane2", 32'h10, 32'h11BB_3344, 1'b0);
        wr(32'h13, 32'h9900_0000, 4'b1000);
        chk("dm_lane3_unaligned", 32'h10, 32'h99BB_3344, 1'b0);
        wr(32'h3FFC, 32'hDEAD_BEEF, 4'b1111);
        chk("dm_top_word", 32'h3FFC, 32'hDEAD_BEEF, 1'b0);

        wr(32'h5000, 32'hFFFF_FFFF, 4'b1111);
        chk("oor_5000", 32'h5000, 32'h0, 1'b0);
        chk("oor_alias_1000", 32'h1000, 32'h0, 1'b0);
        chk("oor_4000", 32'h4000, 32'h0, 1'b0);
        wr(TC, 32'h9, 4'b0011);
        chk("tc_partial", TC, 32'h0, 1'b0);
        wr(TC + 32'd8, 32'h55, 4'b1111);
        chk("count_ro", TC + 32'd8, 32'h0, 1'b0);
        wr(TC + 32'd4, 32'h1234, 4'b1111);
        chk("preset_rb", TC + 32'd4, 32'h1234, 1'b0);

        // one-shot, PRESET=3, CTRL=0x9 at E0
        wr(TC + 32'd4, 32'd3, 4'b1111);
        wr(TC, 32'h9, 4'b1111);
        idle(2);
        chk("os_E2", TC + 32'd8, 32'd3, 1'b0);
        chk("os_E3", TC + 32'd8, 32'd2, 1'b0);
        chk("os_E4", TC + 32'd8, 32'd1, 1'b0);
        chk("os_E5", TC + 32'd8, 32'd0, 1'b1);
        chk("os_E6_ctrl", TC, 32'h8, 1'b1);
        chk("os_E7_hold", TC, 32'h8, 1'b1);
        wr(TC, 32'h0, 4'b1111);
        chk("os_clear", TC, 32'h0, 1'b0);

        // auto-reload, PRESET=2, CTRL=0xB
        wr(TC + 32'd4, 32'd2, 4'b1111);
        wr(TC, 32'hB, 4'b1111);
        idle(1);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("ar_E%0d", i + 1), TC + 32'd8, ar_cnt[i], ar_irq[i]);
        end
        wr(TC, 32'h0, 4'b1111);
        idle(3);

        // auto-reload with IM=0
        wr(TC, 32'h3, 4'b1111);
        idle(2);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("im0_G%0d", i + 2), TC + 32'd8, ar_cnt[i+1], 1'b0);
        end
        wr(TC, 32'h0, 4'b1111);
        idle(3);

        // stop mid-count
        wr(TC + 32'd4, 32'd10, 4'b1111);
        wr(TC, 32'h1, 4'b1111);
        idle(3);
        wr(TC, 32'h8, 4'b1111);
        chk("stop_H4", TC + 32'd8, 32'd8, 1'b0);
        chk("stop_H5", TC + 32'd8, 32'd8, 1'b0);
        idle(3);
        chk("stop_frozen", TC + 32'd8, 32'd8, 1'b0);
        chk("stop_ctrl", TC, 32'h8, 1'b0);

        // reset during CNT with DM dirty
        wr(TC + 32'd4, 32'd20, 4'b1111);
        wr(TC, 32'h9, 4'b1111);
        idle(5);
        chk("pre_rst_count", TC + 32'd8, 32'd17, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mr_count",  TC + 32'd8, 32'h0, 1'b0);
        chk("mr_ctrl",   TC,         32'h0, 1'b0);
        chk("mr_preset", TC + 32'd4, 32'h0, 1'b0);
        chk("mr_dm_10",  32'h10,     32'h0, 1'b0);
        chk("mr_dm_3ffc", 32'h3FFC,  32'h0, 1'b0);
        idle(5);
        chk("mr_idle_count", TC + 32'd8, 32'h0, 1'b0);

        idle(2);
        if (exp_q.size() != 0) begin
            nmiss++;
            $display("FAIL scoreboard_drain: %0d expected entries left, want 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
